// File: rtl/swivm_mem_arbiter.sv
// Two-port arbiter in front of the single-port SwiVM memory.
// It keeps one transaction in flight, drives a registered bus and returns read data per port.
module swivm_mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter bit RR      = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i0_req,
  input  logic [15:0] i0_addr,
  input  logic [31:0] i0_wrdata,
  input  logic [1:0]  i0_size,
  input  logic        i0_we,
  output logic        o0_gnt,
  output logic        o0_done,
  output logic [31:0] o0_rddata,
  input  logic        i1_req,
  input  logic [15:0] i1_addr,
  input  logic [31:0] i1_wrdata,
  input  logic [1:0]  i1_size,
  input  logic        i1_we,
  output logic        o1_gnt,
  output logic        o1_done,
  output logic [31:0] o1_rddata,
  output logic [15:0] o_addr,
  output logic [31:0] o_wrdata,
  output logic [1:0]  o_size,
  output logic        o_we,
  input  logic [31:0] i_rddata,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_win;
  logic        r_last;
  logic        r_rd;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_done0;
  logic        r_done1;
  logic [15:0] r_addr;
  logic [31:0] r_wrdata;
  logic [1:0]  r_size;
  logic        r_we;
  logic [31:0] r_rddata0;
  logic [31:0] r_rddata1;
  logic        w_any;
  logic        w_win;

  // Handshake: iN_req is a level held until oN_gnt. oN_gnt and oN_done are
  // one-cycle pulses. The request fields are captured on the cycle that raises gnt.
  assign w_any = i0_req | i1_req;

  always_comb begin
    w_win = i1_req;
    if (i0_req && i1_req) w_win = RR ? ~r_last : 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_win     <= 1'b0;
      r_last    <= 1'b1;
      r_rd      <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_addr    <= 16'd0;
      r_wrdata  <= 32'd0;
      r_size    <= 2'b11;
      r_we      <= 1'b1;
      r_rddata0 <= 32'd0;
      r_rddata1 <= 32'd0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_win    <= w_win;
            r_last   <= w_win;
            r_addr   <= w_win ? i1_addr   : i0_addr;
            r_wrdata <= w_win ? i1_wrdata : i0_wrdata;
            r_size   <= w_win ? i1_size   : i0_size;
            r_we     <= w_win ? i1_we     : i0_we;
            r_rd     <= w_win ? i1_we     : i0_we;
            r_gnt0   <= ~w_win;
            r_gnt1   <= w_win;
            r_cnt    <= 4'(MEM_LAT - 1);
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A write strobe lasts for this single cycle only.
          r_we    <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            if (r_rd) begin
              if (r_win) r_rddata1 <= i_rddata;
              else       r_rddata0 <= i_rddata;
            end
            r_done0 <= ~r_win;
            r_done1 <= r_win;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o0_gnt      = r_gnt0;
  assign o1_gnt      = r_gnt1;
  assign o0_done     = r_done0;
  assign o1_done     = r_done1;
  assign o0_rddata   = r_rddata0;
  assign o1_rddata   = r_rddata1;
  assign o_addr      = r_addr;
  assign o_wrdata    = r_wrdata;
  assign o_size      = r_size;
  assign o_we        = r_we;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule
